// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag logic for the SDRAM async FIFO.
// Produces Gray wptr for the read side plus full/level/ack/overflow.
module fifo_wptr_full #(
    parameter int FIFO_addr_size = 2,
    parameter int AF_MARGIN      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [FIFO_addr_size:0]   rptr_sync,
    output logic [FIFO_addr_size-1:0] waddr,
    output logic [FIFO_addr_size:0]   wptr,
    output logic                      full,
    output logic                      almost_full,
    output logic [FIFO_addr_size:0]   wr_level,
    output logic                      wr_ack,
    output logic                      overflow
);

    localparam int AW    = FIFO_addr_size;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [PW-1:0] AF_TH   = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] TOP_INV = {2'b11, {(PW-2){1'b0}}};

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] level_next;
    logic          accept;
    logic          full_next;

    always_comb begin
        accept     = wr_en & ~full;
        wbin_next  = wbin + {{AW{1'b0}}, accept};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Gray-to-binary: each bit is the XOR of itself and all bits above it.
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_sync[i] = ^(rptr_sync >> i);
        end
    end

    always_comb begin
        level_next = wbin_next - rbin_sync;
        full_next  = (wgray_next == (rptr_sync ^ TOP_INV));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= full_next;
            almost_full <= (level_next >= AF_TH);
            wr_level    <= level_next;
            wr_ack      <= accept;
            overflow    <= wr_en & full;
        end
    end

    assign waddr = wbin[AW-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: integer-count model, directed fill/drain/wrap
// and mid-run reset, then randomized write/read-advance traffic.
module tb_fifo_wptr_full;

    localparam int AW    = 2;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AFM   = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [PW-1:0] rptr_sync;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;
    logic          wr_ack;
    logic          overflow;

    fifo_wptr_full #(
        .FIFO_addr_size(AW),
        .AF_MARGIN     (AFM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rptr_sync  (rptr_sync),
        .waddr      (waddr),
        .wptr       (wptr),
        .full       (full),
        .almost_full(almost_full),
        .wr_level   (wr_level),
        .wr_ack     (wr_ack),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: counts of accepted writes and reads, not pointers.
    int w_cnt   = 0;
    int r_cnt   = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_af    = 0;
    bit m_ack   = 0;
    bit m_ovf   = 0;
    bit chk_on  = 0;
    logic [PW-1:0] prev_wptr = '0;

    function automatic logic [PW-1:0] gray(input int v);
        logic [PW-1:0] b;
        b = v[PW-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        w_cnt   = 0;
        r_cnt   = 0;
        m_level = 0;
        m_full  = 0;
        m_af    = 0;
        m_ack   = 0;
        m_ovf   = 0;
        prev_wptr = '0;
    endtask

    task automatic cycle(input bit we, input int rc);
        wr_en     = we;
        r_cnt     = rc;
        rptr_sync = gray(rc);
        @(posedge clk);
        m_ovf = we && m_full;
        m_ack = we && !m_full;
        if (m_ack) w_cnt++;
        m_level = w_cnt - r_cnt;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= DEPTH - AFM);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wptr"}, wptr, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_af"}, almost_full, 0);
        check({tag, "_level"}, wr_level, 0);
        check({tag, "_ack"}, wr_ack, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("wptr", wptr, gray(w_cnt));
            check("waddr", waddr, w_cnt % DEPTH);
            check("full", full, m_full);
            check("almost_full", almost_full, m_af);
            check("wr_level", wr_level, m_level);
            check("wr_ack", wr_ack, m_ack);
            check("overflow", overflow, m_ovf);
            check("gray_step", $countones(wptr ^ prev_wptr), m_ack ? 1 : 0);
            prev_wptr = wptr;
        end
    end

    int fill_g[4] = '{1, 3, 2, 6};

    initial begin
        rst       = 1'b0;
        wr_en     = 1'b1;
        rptr_sync = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("in_reset");

        rst = 1'b1;
        cycle(0, 0);
        check_zero("post_reset");
        chk_on = 1;

        for (int k = 0; k < 4; k++) begin
            check("fill_waddr", waddr, k);
            cycle(1, 0);
            check("fill_wptr", wptr, fill_g[k]);
            check("fill_ack", wr_ack, 1);
            if (k == 1) check("fill_af_lo", almost_full, 0);
            if (k == 2) check("fill_af_hi", almost_full, 1);
            if (k < 3) check("fill_not_full", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_level", wr_level, 4);
        check("model_level4", m_level, 4);

        for (int k = 0; k < 2; k++) begin
            cycle(1, 0);
            check("ovf_pulse", overflow, 1);
            check("ovf_noack", wr_ack, 0);
            check("ovf_wptr", wptr, 6);
            check("ovf_level", wr_level, 4);
        end

        cycle(0, 1);
        check("drain_full", full, 0);
        check("drain_level", wr_level, 3);
        check("drain_idle", wr_ack | overflow, 0);
        cycle(1, 1);
        check("refill_full", full, 1);
        check("refill_wptr", wptr, 7);

        while (w_cnt < 14) begin
            cycle(1, w_cnt - 2);
            check("wrap_not_full", full, 0);
        end
        check("wrap_model_pins", w_cnt, 14);

        cycle(0, w_cnt - 2);
        check("pre_rst_level", wr_level, 2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_zero("mid_reset");
        #1;
        rst = 1'b1;
        check("post_rst_waddr", waddr, 0);
        cycle(1, 0);
        check("post_rst_wptr", wptr, 1);

        for (int n = 0; n < 2000; n++) begin
            int rc;
            rc = r_cnt;
            if (($urandom % 3 == 0) && r_cnt < w_cnt) rc = r_cnt + 1;
            cycle(($urandom % 4) != 0, rc);
        end

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and full-flag generator for the async FIFO in the SDRAM 166 MHz path. It runs entirely in the write clock domain. It keeps the binary write address for the dual-port RAM and the registered Gray write pointer. The Gray pointer is handed to the two-flop synchronizer toward the read domain. It also consumes the read pointer that the same synchronizer type has already brought into this domain. From that pointer it produces full, almost_full, fill level, write acknowledge and overflow indications.

Parameters:
FIFO_addr_size, 2, RAM address width; depth = 2**FIFO_addr_size; pointers are FIFO_addr_size+1 bits; legal values are 2 or more.
AF_MARGIN, 1, almost_full asserts when level >= depth - AF_MARGIN; legal range is 1 to depth-1.

Ports:
clk  input  1  write-domain clock.
rst  input  1  asynchronous active-low reset.
wr_en  input  1  write request from the producer.
rptr_sync  input  FIFO_addr_size+1  Gray read pointer, already synchronized into clk.
waddr  output  FIFO_addr_size  RAM write address, equal to the low bits of the binary write pointer.
wptr  output  FIFO_addr_size+1  registered Gray write pointer, sent to the synchronizer.
full  output  1  registered full flag.
almost_full  output  1  registered almost-full flag.
wr_level  output  FIFO_addr_size+1  registered conservative fill level, range 0..depth.
wr_ack  output  1  one-cycle pulse; the previous cycle's write was accepted.
overflow  output  1  one-cycle pulse; the previous cycle's write was rejected.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst.
- Reset values: the internal binary pointer wbin is 0; wptr, waddr, full, almost_full, wr_level, wr_ack and overflow are all 0.
- Acceptance: accept = wr_en & ~full, using the registered full. A write is never accepted while full=1.
- Binary pointer: wbin_next = wbin + accept, modulo 2**(FIFO_addr_size+1). It wraps naturally from all-ones to 0.
- Gray pointer: wgray_next = (wbin_next >> 1) ^ wbin_next. wptr is registered from wgray_next, so it changes at most one bit per clk.
- Address: waddr = wbin[FIFO_addr_size-1:0] from the register, not the next value. RAM write data is presented with the same address in the accepting cycle.
- Full: full <= (wgray_next == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}).
  - full asserts on the same edge that accepts the final free slot.
  - It deasserts on the first edge after rptr_sync advances.
- Level: rbin_sync is the Gray-to-binary conversion of rptr_sync (XOR prefix from the MSB). wr_level <= wbin_next - rbin_sync, computed modulo 2**(FIFO_addr_size+1).
- Almost full: almost_full <= (wbin_next - rbin_sync) >= depth - AF_MARGIN.
- Pulses: wr_ack <= accept. overflow <= wr_en & full. Exactly one of the two is high the cycle after any wr_en, and neither is high otherwise.
- Stale read pointer: rptr_sync lags the true read pointer by 2 or more clk cycles. full and level are therefore pessimistic only, never optimistic.
- Simultaneous write and read advance at full: the write is rejected, because full is the registered value. full then clears on the next edge.
- Reset mid-operation: all state returns to 0 asynchronously, with no glitch to a non-Gray value once released. The read side must be reset concurrently.
- No combinational path from wr_en to any output.

Test Plan:
- Reset: hold rst=0, toggle clk and wr_en=1 -> all outputs 0; after release with rptr_sync=000 and wr_en=0, outputs remain 0.
- Fill, depth 4 (FIFO_addr_size=2): wr_en=1 for 4 cycles with rptr_sync=000 -> wptr goes 001, 011, 010, 110 and waddr goes 0, 1, 2, 3; full=1 after the 4th edge; almost_full=1 after the 3rd edge; wr_level=4; wr_ack high 4 cycles.
- Overflow: continue wr_en=1 while full -> overflow=1 each cycle, wr_ack=0, wptr holds 110, wr_level holds 4.
- Drain release: from full, set rptr_sync=001 with wr_en=0 -> full=0 and wr_level=3 after one edge; the next write makes full=1 again with wptr=111.
- Wrap: interleave writes with rptr_sync tracking so that 9 writes complete -> wptr passes 100 then 000 then 001; waddr wraps 3 to 0; full is never set when the level is below 4; every wptr step changes exactly one bit, which the bench checks with a popcount assertion.
- Mid-run reset: assert rst low asynchronously between edges at level 2 -> all outputs go to 0 immediately; after release the next write produces wptr=001 and waddr=0.
